pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequencing controller for the 5-stage 16-bit load-store pipeline (fetch/decode/execute/mem/writeback).
//  Drives pcwrite plus write/flush enables of the fd, de, em and mw inter-stage registers.
//  Detects load-use hazards, squashes on taken branches, freezes the pipe on memory wait and selects ALU operand forwarding.
//  Sits beside control_component; its enables replace the constant write=1 on the stage registers.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive MEMWAIT cycles before the HALT error state
//  CNT_W        16  width of stall_count / flush_count
// PORTS
//  clock          in   1      pipeline clock, all state on posedge
//  reset          in   1      synchronous, active-low reset
//  id_rs1,id_rs2  in   4      source regs of instruction in decode
//  id_use1,id_use2 in  1      decode instruction actually reads rs1/rs2
//  ex_rs1,ex_rs2  in   4      source regs of instruction in execute
//  ex_rd          in   4      dest reg in execute
//  ex_memread     in   1      execute instruction is a load
//  ex_branch_taken in  1      branch in execute resolved taken
//  mem_rd,wb_rd   in   4      dest regs in mem / writeback
//  mem_regwrite,wb_regwrite in 1  those stages write the register file
//  mem_req        in   1      mem stage performs a load/store this cycle
//  mem_ready      in   1      data memory completes access this cycle
//  pcwrite        out  1      PC register enable
//  fd_write,de_write,em_write,mw_write out 1  stage register enables
//  fd_flush,de_flush out 1    load bubble (all-zero NOP) into fd / de
//  fwd_a,fwd_b    out  2      ALU operand select: 00 regfile, 01 em_aluout, 10 writeback data
//  halted         out  1      sticky memory-timeout error
//  stall_count,flush_count out CNT_W  saturating event counters
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state<=RUN, wait_cnt<=0, counters<=0, halted<=0.
//    While reset is low, outputs are forced: all writes and pcwrite 0, both flushes 1, fwd 00.
//  - FSM states: RUN, MEMWAIT, HALT.
//    Enables are combinational from state plus inputs; zero-latency, effective at the same posedge.
//  - RUN, priority high->low:
//    1) mem_req && !mem_ready: all writes and pcwrite 0, no flush; next MEMWAIT, wait_cnt<=1.
//    2) ex_branch_taken: pcwrite=1, fd_flush=1, de_flush=1, em/mw write 1; flush_count++.
//       A load-use hazard in the same cycle is ignored (decode is squashed).
//    3) load-use hazard = ex_memread && ex_rd!=0 && ((id_use1&&id_rs1==ex_rd)||(id_use2&&id_rs2==ex_rd)).
//       Action: pcwrite=0, fd_write=0, de_flush=1, em/mw write 1; stall_count++.
//       Exactly one bubble per hazard, with no extra state.
//    4) otherwise: all enables 1, no flush.
//  - MEMWAIT: pipe fully frozen (all writes 0, no flush); ex_branch_taken is deferred, not lost.
//    mem_ready=1 -> same cycle behaves as RUN rule 2-4 evaluation; next RUN, wait_cnt<=0.
//    mem_ready=0 -> wait_cnt++; stall_count++ each frozen cycle.
//    When wait_cnt==MEM_TIMEOUT with no mem_ready -> next HALT.
//  - HALT: halted=1, all writes/pcwrite 0, no flush; leaves only via reset.
//  - Forwarding (independent of state): fwd_a=01 if mem_regwrite&&mem_rd!=0&&mem_rd==ex_rs1.
//    Else 10 if wb_regwrite&&wb_rd!=0&&wb_rd==ex_rs1. Else 00. fwd_b identical on ex_rs2.
//    Mem stage has priority over wb. Register 0 never forwards or stalls.
//  - Counters saturate at all-ones, never wrap. Both counters increment on any cycle its event occurs.
//  - Reset mid-MEMWAIT or in HALT: next cycle RUN, counters 0.
// TESTING
//  - Reset low 2 cycles, then high -> outputs forced values during reset; then all enables 1, fwd 00, counters 0.
//  - ex_memread=1, ex_rd=3, id_rs1=3, id_use1=1 for one cycle -> pcwrite=0, fd_write=0, de_flush=1, stall_count=1.
//    Same stimulus with ex_rd=0 -> no stall.
//  - ex_branch_taken=1 with the load-use hazard above in the same cycle -> fd_flush=de_flush=1, pcwrite=1.
//    flush_count=1, stall_count unchanged.
//  - mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles (all writes 0), RUN after.
//    Branch held during the wait flushes on the ready cycle.
//  - mem_req=1, mem_ready=0 for MEM_TIMEOUT+2 cycles -> HALT, halted=1 sticky.
//    Reset low clears halted and returns to RUN.
//  - mem_rd=5, wb_rd=5, both regwrite, ex_rs1=5, ex_rs2=5 -> fwd_a=fwd_b=01.
//    With mem_regwrite=0 -> 10. With rd=0 -> 00.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the hazard controller's pipeline-side signals.
//   master : datapath side, drives stage/register info, observes enables.
//   slave  : controller side (pipeline_hazard_ctrl).
//   Inputs to the controller: decode/execute source regs, execute dest and
//   load/branch status, mem/wb dest regs and regwrite, mem request/ready.
//   Outputs from the controller: pcwrite, stage write/flush enables,
//   forwarding selects, halted flag, stall/flush event counters.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_rs1;
  logic [3:0]       id_rs2;
  logic             id_use1;
  logic             id_use2;
  logic [3:0]       ex_rs1;
  logic [3:0]       ex_rs2;
  logic [3:0]       ex_rd;
  logic             ex_memread;
  logic             ex_branch_taken;
  logic [3:0]       mem_rd;
  logic [3:0]       wb_rd;
  logic             mem_regwrite;
  logic             wb_regwrite;
  logic             mem_req;
  logic             mem_ready;

  logic             pcwrite;
  logic             fd_write;
  logic             de_write;
  logic             em_write;
  logic             mw_write;
  logic             fd_flush;
  logic             de_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use1, id_use2,
    output ex_rs1, ex_rs2, ex_rd, ex_memread, ex_branch_taken,
    output mem_rd, wb_rd, mem_regwrite, wb_regwrite,
    output mem_req, mem_ready,
    input  pcwrite, fd_write, de_write, em_write, mw_write,
    input  fd_flush, de_flush, fwd_a, fwd_b,
    input  halted, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use1, id_use2,
    input  ex_rs1, ex_rs2, ex_rd, ex_memread, ex_branch_taken,
    input  mem_rd, wb_rd, mem_regwrite, wb_regwrite,
    input  mem_req, mem_ready,
    output pcwrite, fd_write, de_write, em_write, mw_write,
    output fd_flush, de_flush, fwd_a, fwd_b,
    output halted, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequencing controller for the 5-stage 16-bit load-store pipeline.
//   Generates PC / inter-stage register write and flush enables, inserts
//   one bubble per load-use hazard, squashes decode/fetch on a taken branch,
//   freezes the whole pipe while data memory is busy and halts on a memory
//   timeout. ALU operand forwarding selects are produced independently.
// Ports
//   clock  : pipeline clock, all state on posedge
//   reset  : synchronous, active-low
//   hz     : pipeline_hazard_ctrl_if.slave (hazard inputs, enables,
//            forwarding selects, halted flag, saturating counters)
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int            WC_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [WC_W-1:0]   wait_cnt, wait_cnt_nx;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic              stall_ev, flush_ev;
  logic              load_use;
  logic              eval_pipe;

  logic pcwrite, fd_write, de_write, em_write, mw_write, fd_flush, de_flush;

  // Register 0 is hard-wired zero, so a load into it never creates a hazard.
  always_comb begin
    load_use = hz.ex_memread && (hz.ex_rd != 4'd0) &&
               ((hz.id_use1 && (hz.id_rs1 == hz.ex_rd)) ||
                (hz.id_use2 && (hz.id_rs2 == hz.ex_rd)));
  end

  // Next state and enables. RUN and the ready cycle of MEMWAIT share the
  // branch / load-use / normal evaluation via eval_pipe, which is how a
  // branch held during a memory wait is acted on once memory completes.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    eval_pipe   = 1'b0;
    pcwrite     = 1'b0;
    fd_write    = 1'b0;
    de_write    = 1'b0;
    em_write    = 1'b0;
    mw_write    = 1'b0;
    fd_flush    = 1'b0;
    de_flush    = 1'b0;

    unique case (state)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          state_nx    = MEMWAIT;
          wait_cnt_nx = WC_W'(1);
          stall_ev    = 1'b1;
        end else begin
          eval_pipe = 1'b1;
        end
      end
      MEMWAIT: begin
        if (hz.mem_ready) begin
          eval_pipe   = 1'b1;
          state_nx    = RUN;
          wait_cnt_nx = '0;
        end else begin
          stall_ev = 1'b1;
          if (wait_cnt == WC_MAX) begin
            state_nx = HALT;
          end else begin
            wait_cnt_nx = wait_cnt + 1'b1;
          end
        end
      end
      HALT: begin
      end
      default: begin
        state_nx    = RUN;
        wait_cnt_nx = '0;
      end
    endcase

    if (eval_pipe) begin
      if (hz.ex_branch_taken) begin
        // Squash fetch and decode: both registers load a NOP bubble.
        pcwrite  = 1'b1;
        fd_write = 1'b1;
        de_write = 1'b1;
        em_write = 1'b1;
        mw_write = 1'b1;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        flush_ev = 1'b1;
      end else if (load_use) begin
        // Hold PC and fd; de takes a bubble while the load advances, so the
        // hazard clears on its own next cycle without extra state.
        de_write = 1'b1;
        em_write = 1'b1;
        mw_write = 1'b1;
        de_flush = 1'b1;
        stall_ev = 1'b1;
      end else begin
        pcwrite  = 1'b1;
        fd_write = 1'b1;
        de_write = 1'b1;
        em_write = 1'b1;
        mw_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      if (stall_ev && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush_ev && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  // Output drive; while reset is low the pipe is held with bubbles loaded.
  always_comb begin
    if (!reset) begin
      hz.pcwrite  = 1'b0;
      hz.fd_write = 1'b0;
      hz.de_write = 1'b0;
      hz.em_write = 1'b0;
      hz.mw_write = 1'b0;
      hz.fd_flush = 1'b1;
      hz.de_flush = 1'b1;
    end else begin
      hz.pcwrite  = pcwrite;
      hz.fd_write = fd_write;
      hz.de_write = de_write;
      hz.em_write = em_write;
      hz.mw_write = mw_write;
      hz.fd_flush = fd_flush;
      hz.de_flush = de_flush;
    end
  end

  // Forwarding: mem stage is newer than writeback, so it wins.
  always_comb begin
    hz.fwd_a = 2'b00;
    hz.fwd_b = 2'b00;
    if (reset) begin
      if (hz.mem_regwrite && (hz.mem_rd != 4'd0) && (hz.mem_rd == hz.ex_rs1)) begin
        hz.fwd_a = 2'b01;
      end else if (hz.wb_regwrite && (hz.wb_rd != 4'd0) && (hz.wb_rd == hz.ex_rs1)) begin
        hz.fwd_a = 2'b10;
      end
      if (hz.mem_regwrite && (hz.mem_rd != 4'd0) && (hz.mem_rd == hz.ex_rs2)) begin
        hz.fwd_b = 2'b01;
      end else if (hz.wb_regwrite && (hz.wb_rd != 4'd0) && (hz.wb_rd == hz.ex_rs2)) begin
        hz.fwd_b = 2'b10;
      end
    end
  end

  always_comb begin
    hz.halted      = (state == HALT);
    hz.stall_count = stall_cnt;
    hz.flush_count = flush_cnt;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int TB_CNT_W   = 4;
  localparam int TB_TIMEOUT = 16;

  // Enable bundle order: pcwrite, fd_write, de_write, em_write, mw_write, fd_flush, de_flush
  localparam logic [6:0] EN_RESET  = 7'b00000_11;
  localparam logic [6:0] EN_RUN    = 7'b11111_00;
  localparam logic [6:0] EN_LDUSE  = 7'b00111_01;
  localparam logic [6:0] EN_BRANCH = 7'b11111_11;
  localparam logic [6:0] EN_FROZEN = 7'b00000_00;

  logic clock;
  logic reset;
  int   total;
  int   passed;
  int   failed;

  pipeline_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) hz ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] en();
    return {hz.pcwrite, hz.fd_write, hz.de_write, hz.em_write, hz.mw_write,
            hz.fd_flush, hz.de_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use1 = 1'b0; hz.id_use2 = 1'b0;
    hz.ex_rs1 = '0; hz.ex_rs2 = '0; hz.ex_rd = '0;
    hz.ex_memread = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.mem_rd = '0; hz.wb_rd = '0; hz.mem_regwrite = 1'b0; hz.wb_regwrite = 1'b0;
    hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    reset = 1'b0;
    clear_inputs();
    // forwarding match present during reset must still read 00
    hz.mem_rd = 4'd5; hz.mem_regwrite = 1'b1; hz.ex_rs1 = 4'd5;

    // reset held for two cycles
    #1;
    chk("reset_en", 32'(en()), 32'(EN_RESET));
    chk("reset_fwd_a", 32'(hz.fwd_a), 32'd0);
    @(posedge clock); #1;
    chk("reset_stall", 32'(hz.stall_count), 32'd0);
    chk("reset_flush", 32'(hz.flush_count), 32'd0);
    chk("reset_halted", 32'(hz.halted), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    #1;
    chk("run_en", 32'(en()), 32'(EN_RUN));
    chk("run_fwd", 32'({hz.fwd_a, hz.fwd_b}), 32'd0);

    // load-use on rs1
    @(negedge clock);
    hz.ex_memread = 1'b1; hz.ex_rd = 4'd3; hz.id_rs1 = 4'd3; hz.id_use1 = 1'b1;
    #1 chk("lu_rs1_en", 32'(en()), 32'(EN_LDUSE));
    @(posedge clock); #1;
    chk("lu_rs1_stall", 32'(hz.stall_count), 32'd1);

    // same with ex_rd = 0: no stall
    @(negedge clock);
    hz.ex_rd = 4'd0; hz.id_rs1 = 4'd0;
    #1 chk("lu_r0_en", 32'(en()), 32'(EN_RUN));
    @(posedge clock); #1;
    chk("lu_r0_stall", 32'(hz.stall_count), 32'd1);

    // load-use on rs2
    @(negedge clock);
    hz.ex_rd = 4'd7; hz.id_rs2 = 4'd7; hz.id_use2 = 1'b1; hz.id_use1 = 1'b0;
    #1 chk("lu_rs2_en", 32'(en()), 32'(EN_LDUSE));
    @(posedge clock); #1;
    chk("lu_rs2_stall", 32'(hz.stall_count), 32'd2);

    // matching reg but decode does not read it
    @(negedge clock);
    hz.id_use2 = 1'b0;
    #1 chk("lu_nouse_en", 32'(en()), 32'(EN_RUN));

    // branch taken with simultaneous load-use
    @(negedge clock);
    hz.ex_rd = 4'd3; hz.id_rs1 = 4'd3; hz.id_use1 = 1'b1; hz.ex_branch_taken = 1'b1;
    #1 chk("br_lu_en", 32'(en()), 32'(EN_BRANCH));
    @(posedge clock); #1;
    chk("br_flush_cnt", 32'(hz.flush_count), 32'd1);
    chk("br_stall_cnt", 32'(hz.stall_count), 32'd2);

    // memory wait: 3 frozen cycles, branch held, ready on the 4th
    @(negedge clock);
    clear_inputs();
    hz.mem_req = 1'b1;
    #1 chk("mw_freeze0", 32'(en()), 32'(EN_FROZEN));
    @(negedge clock);
    hz.ex_branch_taken = 1'b1;
    #1 chk("mw_freeze1", 32'(en()), 32'(EN_FROZEN));
    @(negedge clock);
    #1 chk("mw_freeze2", 32'(en()), 32'(EN_FROZEN));
    chk("mw_flush_held", 32'(hz.flush_count), 32'd1);
    @(negedge clock);
    hz.mem_ready = 1'b1;
    #1 chk("mw_ready_br", 32'(en()), 32'(EN_BRANCH));
    @(posedge clock); #1;
    chk("mw_ready_flush", 32'(hz.flush_count), 32'd2);
    @(negedge clock);
    clear_inputs();
    #1 chk("mw_back_run", 32'(en()), 32'(EN_RUN));

    // memory timeout -> HALT
    @(negedge clock);
    hz.mem_req = 1'b1;
    for (int i = 1; i <= TB_TIMEOUT + 2; i++) begin
      @(posedge clock); #1;
      if (i == TB_TIMEOUT) chk("to_not_yet", 32'(hz.halted), 32'd0);
      if (i == TB_TIMEOUT + 1) chk("to_halted", 32'(hz.halted), 32'd1);
    end
    chk("to_stall_sat", 32'(hz.stall_count), 32'hF);
    @(negedge clock);
    hz.mem_ready = 1'b1; hz.ex_branch_taken = 1'b1;
    #1 chk("halt_en", 32'(en()), 32'(EN_FROZEN));
    @(posedge clock); #1;
    chk("halt_sticky", 32'(hz.halted), 32'd1);
    chk("halt_flush_cnt", 32'(hz.flush_count), 32'd2);

    // reset leaves HALT
    @(negedge clock);
    clear_inputs();
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_halted", 32'(hz.halted), 32'd0);
    chk("rst_stall", 32'(hz.stall_count), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rst_run_en", 32'(en()), 32'(EN_RUN));

    // forwarding
    @(negedge clock);
    hz.mem_rd = 4'd5; hz.wb_rd = 4'd5; hz.mem_regwrite = 1'b1; hz.wb_regwrite = 1'b1;
    hz.ex_rs1 = 4'd5; hz.ex_rs2 = 4'd5;
    #1 chk("fwd_mem", 32'({hz.fwd_a, hz.fwd_b}), 32'b0101);
    hz.mem_regwrite = 1'b0;
    #1 chk("fwd_wb", 32'({hz.fwd_a, hz.fwd_b}), 32'b1010);
    hz.mem_regwrite = 1'b1; hz.mem_rd = 4'd0; hz.wb_rd = 4'd0;
    hz.ex_rs1 = 4'd0; hz.ex_rs2 = 4'd0;
    #1 chk("fwd_r0", 32'({hz.fwd_a, hz.fwd_b}), 32'b0000);
    hz.mem_rd = 4'd5; hz.ex_rs1 = 4'd5; hz.wb_rd = 4'd6; hz.ex_rs2 = 4'd6;
    #1 chk("fwd_mixed", 32'({hz.fwd_a, hz.fwd_b}), 32'b0110);

    // flush counter saturation: 15 more branches from 0
    @(negedge clock);
    clear_inputs();
    hz.ex_branch_taken = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge clock);
    end
    #1 chk("flush_sat", 32'(hz.flush_count), 32'hF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
